// File: rtl/adc_sample_framer_pkg.sv
// Shared constants and types for the ADC sample framer.
// Frame header, FSM states and status widths live here.
package adc_sample_framer_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int DROP_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEQ,
        ST_DATA,
        ST_CSUM
    } state_e;

    // Byte idx of a sample word, most significant byte first.
    function automatic logic [7:0] sample_byte(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        unique case (idx)
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/adc_sample_framer_if.sv
// Byte stream from the framer to the host transport.
// Plain valid/ready handshake; m_last marks the checksum byte.
interface adc_sample_framer_if;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/adc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with fill count.
// Writes are refused while the registered fill equals the depth.
module adc_sync_fifo #(
    parameter int W  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          arstn,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [W-1:0]  rd_next,
    output logic [AW:0]   fill,
    output logic          full
);

    localparam logic [AW:0]   DEPTH    = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   FILL_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic          do_wr;
    logic          do_rd;

    assign full    = (fill_q == DEPTH);
    assign do_wr   = wr_en && !full && !clear;
    assign do_rd   = rd_en && (fill_q != '0) && !clear;
    assign fill    = fill_q;
    assign rd_data = mem[rd_ptr_q];
    assign rd_next = mem[rd_ptr_q + PTR_ONE];

    // Pointer and occupancy update; clear empties the FIFO.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({do_wr, do_rd})
                2'b10:   fill_d = fill_q + FILL_ONE;
                2'b01:   fill_d = fill_q - FILL_ONE;
                default: fill_d = fill_q;
            endcase
        end
    end

    // Pointer and fill state.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/adc_sample_framer.sv
// Packs 32-bit ADC samples into checksummed byte frames:
// A5, seq, FRAME_LEN x 4 data bytes (MSB first), XOR checksum.
module adc_sample_framer
    import adc_sample_framer_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int FIFO_AW   = 6
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                clear,
    input  logic [31:0]         din,
    input  logic                din_valid,
    adc_sample_framer_if.master m,
    output logic [FIFO_AW:0]    fill,
    output logic                overflow,
    output logic [DROP_W-1:0]   drop_cnt
);

    localparam logic [FIFO_AW:0] FRAME_FILL = FRAME_LEN[FIFO_AW:0];
    localparam logic [7:0]       LAST_SMP   = 8'(FRAME_LEN - 1);

    state_e      state_q;
    logic [7:0]  m_data_q;
    logic        m_valid_q;
    logic        m_last_q;
    logic [7:0]  seq_q;
    logic [7:0]  csum_q;
    logic [1:0]  byte_idx_q;
    logic [7:0]  smp_cnt_q;

    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [31:0] head;
    logic [31:0] head_next;
    logic        fifo_full;
    logic        xfer;
    logic        pop;
    logic        drop;

    assign xfer = m_valid_q && m.m_ready;
    assign pop  = xfer && (state_q == ST_DATA) && (byte_idx_q == 2'd3);
    assign drop = din_valid && fifo_full && !clear;

    adc_sync_fifo #(
        .W  (32),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .arstn   (arstn),
        .clear   (clear),
        .wr_en   (din_valid),
        .wr_data (din),
        .rd_en   (pop),
        .rd_data (head),
        .rd_next (head_next),
        .fill    (fill),
        .full    (fifo_full)
    );

    // Frame sequencer with registered stream outputs and checksum.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= ST_IDLE;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            seq_q      <= '0;
            csum_q     <= '0;
            byte_idx_q <= '0;
            smp_cnt_q  <= '0;
        end else if (clear) begin
            state_q    <= ST_IDLE;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            seq_q      <= '0;
            csum_q     <= '0;
            byte_idx_q <= '0;
            smp_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fill >= FRAME_FILL) begin
                        state_q   <= ST_HDR;
                        m_data_q  <= HDR_BYTE;
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        state_q  <= ST_SEQ;
                        m_data_q <= seq_q;
                        csum_q   <= '0;
                    end
                end
                ST_SEQ: begin
                    if (xfer) begin
                        state_q    <= ST_DATA;
                        m_data_q   <= sample_byte(head, 2'd0);
                        csum_q     <= csum_q ^ m_data_q;
                        byte_idx_q <= 2'd0;
                        smp_cnt_q  <= '0;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ m_data_q;
                        if (byte_idx_q != 2'd3) begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            m_data_q   <= sample_byte(head, byte_idx_q + 2'd1);
                        end else if (smp_cnt_q == LAST_SMP) begin
                            state_q  <= ST_CSUM;
                            m_data_q <= csum_q ^ m_data_q;
                            m_last_q <= 1'b1;
                        end else begin
                            byte_idx_q <= 2'd0;
                            smp_cnt_q  <= smp_cnt_q + 8'd1;
                            m_data_q   <= sample_byte(head_next, 2'd0);
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        state_q   <= ST_IDLE;
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        seq_q     <= seq_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign m.m_data  = m_data_q;
    assign m.m_valid = m_valid_q;
    assign m.m_last  = m_last_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_adc_sample_framer.sv
// Directed bench for adc_sample_framer.
// Main instance FRAME_LEN=2/FIFO_AW=6, second instance FIFO_AW=2.
module tb_adc_sample_framer;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        clear = 1'b0;
    logic        din_valid = 1'b0;
    logic [31:0] din = '0;
    logic [6:0]  fill;
    logic        overflow;
    logic [15:0] drop_cnt;

    logic        clear2 = 1'b0;
    logic        din_valid2 = 1'b0;
    logic [31:0] din2 = '0;
    logic [2:0]  fill2;
    logic        overflow2;
    logic [15:0] drop_cnt2;

    adc_sample_framer_if ifc ();
    adc_sample_framer_if ifc2 ();

    int n_cmp = 0;
    int n_bad = 0;
    int stall_err = 0;
    logic [7:0] got_d [$];
    logic       got_l [$];

    always #5 clk = ~clk;

    adc_sample_framer #(.FRAME_LEN(2), .FIFO_AW(6)) dut (
        .clk       (clk),
        .arstn     (arstn),
        .clear     (clear),
        .din       (din),
        .din_valid (din_valid),
        .m         (ifc),
        .fill      (fill),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    adc_sample_framer #(.FRAME_LEN(2), .FIFO_AW(2)) dut2 (
        .clk       (clk),
        .arstn     (arstn),
        .clear     (clear2),
        .din       (din2),
        .din_valid (din_valid2),
        .m         (ifc2),
        .fill      (fill2),
        .overflow  (overflow2),
        .drop_cnt  (drop_cnt2)
    );

    // Two back-to-back samples into the main instance; returns at the
    // falling edge after the second capture edge.
    task automatic push2(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        din = a;
        din_valid = 1'b1;
        @(negedge clk);
        din = b;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // Collect n bytes from the main stream; rnd toggles m_ready.
    task automatic collect(input int n, input bit rnd, input int budget,
                           output int got);
        logic       pv, pr, pl;
        logic [7:0] pd;
        logic       rdy;
        got = 0;
        pv = 1'b0;
        pr = 1'b1;
        pl = 1'b0;
        pd = '0;
        stall_err = 0;
        got_d.delete();
        got_l.delete();
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (pv && !pr) begin
                if (!ifc.m_valid || ifc.m_data !== pd || ifc.m_last !== pl)
                    stall_err++;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ifc.m_ready = rdy;
            if (ifc.m_valid && rdy) begin
                got_d.push_back(ifc.m_data);
                got_l.push_back(ifc.m_last);
                got++;
            end
            pv = ifc.m_valid;
            pr = rdy;
            pd = ifc.m_data;
            pl = ifc.m_last;
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (ifc.m_valid !== 1'b0 || ifc.m_data !== 8'h00 || ifc.m_last !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stream: got v=%b d=%h l=%b want 0 00 0",
                     ifc.m_valid, ifc.m_data, ifc.m_last);
        end
        n_cmp++;
        if (fill !== 7'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_status: got fill=%0d ov=%b drop=%0d want 0 0 0",
                     fill, overflow, drop_cnt);
        end
        n_cmp++;
        if (ifc2.m_valid !== 1'b0 || fill2 !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_dut2: got v=%b fill=%0d want 0 0",
                     ifc2.m_valid, fill2);
        end
        @(negedge clk);
        arstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp [11];
        int got;
        exp = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h04};
        ifc.m_ready = 1'b0;
        push2(32'h01020304, 32'hA0B0C0D0);
        n_cmp++;
        if (fill !== 7'd2 || ifc.m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_k: got fill=%0d v=%b want 2 0",
                     fill, ifc.m_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (ifc.m_valid !== 1'b1 || ifc.m_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL latency_hdr: got v=%b d=%h want 1 a5",
                     ifc.m_valid, ifc.m_data);
        end
        collect(11, 1'b0, 60, got);
        n_cmp++;
        if (got !== 11) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want 11", got);
        end
        for (int i = 0; i < got; i++) begin
            n_cmp++;
            if (got_d[i] !== exp[i] || got_l[i] !== (i == 10)) begin
                n_bad++;
                $display("FAIL basic_byte%0d: got %h/%b want %h/%b",
                         i, got_d[i], got_l[i], exp[i], (i == 10));
            end
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (fill !== 7'd0 || ifc.m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_drain: got fill=%0d v=%b want 0 0",
                     fill, ifc.m_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [11];
        int got;
        exp = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04,
                8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h05};
        push2(32'h01020304, 32'hA0B0C0D0);
        collect(11, 1'b1, 300, got);
        n_cmp++;
        if (got !== 11) begin
            n_bad++;
            $display("FAIL bp_count: got %0d want 11", got);
        end
        for (int i = 0; i < got; i++) begin
            n_cmp++;
            if (got_d[i] !== exp[i] || got_l[i] !== (i == 10)) begin
                n_bad++;
                $display("FAIL bp_byte%0d: got %h/%b want %h/%b",
                         i, got_d[i], got_l[i], exp[i], (i == 10));
            end
        end
        n_cmp++;
        if (stall_err !== 0) begin
            n_bad++;
            $display("FAIL bp_stable: got %0d stall changes want 0", stall_err);
        end
        ifc.m_ready = 1'b1;
    endtask

    task automatic test_overflow();
        logic [31:0] w [6];
        logic [7:0]  exp [22];
        logic [7:0]  g [22];
        int idx;
        w = '{32'h11223344, 32'h55667788, 32'h99AABBCC,
              32'hDDEEFF00, 32'h0BADF00D, 32'hDEADBEEF};
        exp = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h88,
                8'hA5, 8'h01, 8'h99, 8'hAA, 8'hBB, 8'hCC,
                8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h89};
        ifc2.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din2 = w[i];
            din_valid2 = 1'b1;
        end
        @(negedge clk);
        din_valid2 = 1'b0;
        n_cmp++;
        if (fill2 !== 3'd4 || overflow2 !== 1'b1 || drop_cnt2 !== 16'd2) begin
            n_bad++;
            $display("FAIL ovf_status: got fill=%0d ov=%b drop=%0d want 4 1 2",
                     fill2, overflow2, drop_cnt2);
        end
        idx = 0;
        for (int c = 0; c < 100 && idx < 22; c++) begin
            @(negedge clk);
            ifc2.m_ready = 1'b1;
            if (ifc2.m_valid) begin
                g[idx] = ifc2.m_data;
                idx++;
            end
        end
        n_cmp++;
        if (idx !== 22) begin
            n_bad++;
            $display("FAIL ovf_count: got %0d want 22", idx);
        end
        for (int i = 0; i < idx; i++) begin
            n_cmp++;
            if (g[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL ovf_byte%0d: got %h want %h", i, g[i], exp[i]);
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (ifc2.m_valid !== 1'b0 || fill2 !== 3'd0 || overflow2 !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_after: got v=%b fill=%0d ov=%b want 0 0 1",
                     ifc2.m_valid, fill2, overflow2);
        end
    endtask

    task automatic test_clear();
        int got;
        ifc.m_ready = 1'b1;
        push2(32'h01020304, 32'hA0B0C0D0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (ifc.m_valid !== 1'b1 || ifc.m_data !== 8'h03 || fill !== 7'd2) begin
            n_bad++;
            $display("FAIL clr_pre: got v=%b d=%h fill=%0d want 1 03 2",
                     ifc.m_valid, ifc.m_data, fill);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (ifc.m_valid !== 1'b0 || fill !== 7'd0 || drop_cnt !== 16'd0 ||
            overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_post: got v=%b fill=%0d drop=%0d ov=%b want 0 0 0 0",
                     ifc.m_valid, fill, drop_cnt, overflow);
        end
        push2(32'h01020304, 32'hA0B0C0D0);
        collect(11, 1'b0, 60, got);
        n_cmp++;
        if (got !== 11 || got_d[1] !== 8'h00 || got_d[10] !== 8'h04) begin
            n_bad++;
            $display("FAIL clr_next: got n=%0d seq=%h csum=%h want 11 00 04",
                     got, (got > 1) ? got_d[1] : 8'hxx,
                     (got > 10) ? got_d[10] : 8'hxx);
        end
    endtask

    task automatic test_seq_wrap();
        int got;
        logic [31:0] s0, s1;
        logic [7:0]  seqe, cs;
        logic [63:0] pair;
        logic [63:0] gpair;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int f = 0; f < 257; f++) begin
            s0 = $urandom;
            s1 = $urandom;
            seqe = 8'(f);
            pair = {s0, s1};
            cs = seqe;
            for (int b = 0; b < 8; b++) cs = cs ^ pair[63-8*b -: 8];
            push2(s0, s1);
            collect(11, 1'b0, 60, got);
            n_cmp++;
            if (got !== 11) begin
                n_bad++;
                $display("FAIL wrap_count f%0d: got %0d want 11", f, got);
            end else begin
                gpair = '0;
                for (int b = 0; b < 8; b++) gpair[63-8*b -: 8] = got_d[2+b];
                n_cmp++;
                if (got_d[0] !== 8'hA5 || got_d[1] !== seqe) begin
                    n_bad++;
                    $display("FAIL wrap_seq f%0d: got %h %h want a5 %h",
                             f, got_d[0], got_d[1], seqe);
                end
                n_cmp++;
                if (gpair !== pair) begin
                    n_bad++;
                    $display("FAIL wrap_data f%0d: got %h want %h", f, gpair, pair);
                end
                n_cmp++;
                if (got_d[10] !== cs || got_l[10] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wrap_csum f%0d: got %h/%b want %h/1",
                             f, got_d[10], got_l[10], cs);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        ifc.m_ready = 1'b1;
        push2(32'h01020304, 32'hA0B0C0D0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ifc.m_valid !== 1'b1 || ifc.m_data !== 8'h01 || fill !== 7'd2) begin
            n_bad++;
            $display("FAIL arst_pre: got v=%b d=%h fill=%0d want 1 01 2",
                     ifc.m_valid, ifc.m_data, fill);
        end
        #2;
        arstn = 1'b0;
        #1;
        n_cmp++;
        if (ifc.m_valid !== 1'b0 || ifc.m_data !== 8'h00 || ifc.m_last !== 1'b0 ||
            fill !== 7'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL arst_now: got v=%b d=%h l=%b fill=%0d ov=%b drop=%0d want all 0",
                     ifc.m_valid, ifc.m_data, ifc.m_last, fill, overflow, drop_cnt);
        end
        n_cmp++;
        if (ifc2.m_valid !== 1'b0 || overflow2 !== 1'b0 || drop_cnt2 !== 16'd0) begin
            n_bad++;
            $display("FAIL arst_dut2: got v=%b ov=%b drop=%0d want 0 0 0",
                     ifc2.m_valid, overflow2, drop_cnt2);
        end
        @(negedge clk);
        arstn = 1'b1;
    endtask

    initial begin
        ifc.m_ready = 1'b0;
        ifc2.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_clear();
        test_seq_wrap();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_framer.md
# adc_sample_framer

Packs 32-bit conversion results from the ADC interface (`douta`/`valida`) into byte-wide, checksummed frames for the host link. It sits directly downstream of the ADC interface and upstream of the host transport. It buffers samples in a small synchronous FIFO so that host backpressure does not lose data. It emits a frame only once a full frame of samples is buffered, and it counts samples dropped on overflow.

## Interface
- `FRAME_LEN`, default 16: samples per frame, legal range 1..255, must be ≤ 2^`FIFO_AW`.
- `FIFO_AW`, default 6: FIFO address width; depth = 2^`FIFO_AW` samples.
- `clk`  in  1  clock.
- `arstn`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous flush: FIFO, FSM, sequence counter, status.
- `din`  in  32  sample word from the ADC interface.
- `din_valid`  in  1  one-cycle strobe; `din` is captured on this edge.
- `m_data`  out  8  output byte.
- `m_valid`  out  1  `m_data` is valid.
- `m_last`  out  1  marks the checksum byte (last byte of the frame).
- `m_ready`  in  1  downstream accepts the byte.
- `fill`  out  `FIFO_AW`+1  number of samples currently in the FIFO.
- `overflow`  out  1  sticky flag: at least one sample was dropped.
- `drop_cnt`  out  16  count of dropped samples, saturates at 0xFFFF.

## Operation
- **Frame format:** 0xA5 header, sequence byte, then `FRAME_LEN` × 4 data bytes (MSB first per sample), then checksum byte. Total length = 3 + 4·`FRAME_LEN` bytes.
- **Checksum:** XOR of the sequence byte and all data bytes. The header is excluded.
- **Sequence counter:** 8-bit. Increments when the checksum byte transfers; wraps 255 → 0. Resets to 0.
- **FSM states:** IDLE, HDR, SEQ, DATA, CSUM.
  - IDLE → HDR when `fill` ≥ `FRAME_LEN`.
  - HDR → SEQ on transfer.
  - SEQ → DATA on transfer.
  - DATA stays in DATA, with byte index 0..3 and a sample counter.
  - After byte 3 of sample `FRAME_LEN`-1 transfers: → CSUM.
  - CSUM → IDLE on transfer.
- **Transfer:** `m_valid` && `m_ready` at a rising edge.
- **FIFO pop:** happens on transfer of byte 3 of each sample. The FIFO is first-word-fall-through, so the head word is always visible.
- **Write:** occurs on `din_valid` when registered `fill` < depth. If `fill` == depth the sample is dropped, even if a pop happens on the same edge. A drop sets `overflow` and increments `drop_cnt`, saturating.
- **Simultaneous push and pop** (not full): `fill` is unchanged.
- **`clear`:** on the next edge, FIFO empty, FSM = IDLE, `m_valid` = 0, sequence = 0, `overflow` = 0, `drop_cnt` = 0. This holds mid-frame; the partial frame is abandoned. `clear` overrides a simultaneous `din_valid`, which is discarded and not counted.
- **Reset values:** `m_data` = 0, `m_valid` = 0, `m_last` = 0, `fill` = 0, `overflow` = 0, `drop_cnt` = 0, FSM = IDLE.

## Timing
- All outputs are registered.
- **Handshake:** valid/ready stream. While `m_valid` = 1 and `m_ready` = 0, `m_data` and `m_last` hold stable. `m_valid` never drops without a transfer, except on `clear`.
- **Frame start latency:** the sample that brings `fill` to `FRAME_LEN` is captured at edge k. `fill` updates after edge k, and `m_valid` rises with header 0xA5 after edge k+1.
- **Throughput:** with `m_ready` held at 1, one byte per cycle inside a frame with no bubbles. Exactly one cycle of `m_valid` = 0 between back-to-back frames (IDLE visit).
- **`m_last`:** high only together with the checksum byte.
- **`fill`:** reflects pushes and pops one cycle after the causing edge.

## Structure
- **Shared package:** header constant 0xA5, FSM state enum, `drop_cnt` width.
- **Sub-module `adc_sync_fifo`:** parameterised width/depth, FWFT, with `fill` output and write refused when full. The framer FSM, checksum accumulator and status counters stay in `adc_sample_framer`.

## Test plan
1. **Basic frame:** `FRAME_LEN`=2, `m_ready`=1, push 0x01020304 then 0xA0B0C0D0 → bytes A5 00 01 02 03 04 A0 B0 C0 D0 04, with `m_last` only on the final 04; `fill` returns to 0.
2. **Backpressure:** same stimulus with `m_ready` toggling pseudo-randomly → identical byte sequence, `m_data` stable during every stall, no duplicated or dropped bytes.
3. **Overflow:** `FIFO_AW`=2, `m_ready`=0, push 6 samples → `fill`=4, `overflow`=1, `drop_cnt`=2. Release `m_ready` → frames contain only the first 4 samples.
4. **Sequence wrap:** 257 consecutive frames → sequence bytes 0..255 then 0; checksum correct on every frame.
5. **`clear` mid-frame:** assert during DATA byte 2 → `m_valid`=0 next cycle, `fill`=0, `drop_cnt`=0. The next full frame starts with sequence 00.
6. **Async reset mid-frame:** drop `arstn` during DATA → all outputs go to reset values immediately, independent of `clk`.
